// File: rtl/reg_master_pkg.sv
// Shared types and constants for the byte-stream register-bus master.
// Opcodes, response bytes, bus widths and the frame FSM state encoding.
package reg_master_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    localparam logic [7:0] OP_WR    = 8'h57;
    localparam logic [7:0] OP_RD    = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        READ,
        RESP_HI,
        RESP_LO,
        ACK,
        ERR
    } state_t;

endpackage

// File: rtl/reg_master_tmo.sv
// Inter-byte timeout counter: counts cycles while run is high, restarts on clear,
// and raises expire in the TIMEOUT_CYCLES-th silent cycle.
module reg_master_tmo #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    // The count restarts after expiring so it never wraps past the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || clear || expire) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign expire = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/reg_bus_master.sv
// Host byte-stream to register-bus bridge: decodes write/read frames and issues bus strobes.
// Define REG_MASTER_WR_ACK_EN to answer every completed write with an ACK byte.
module reg_bus_master
    import reg_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              timeout_pulse
);

    state_t            state;
    state_t            state_next;
    logic              is_write;
    logic [DATA_W-1:0] rd_buf;
    logic              accept;
    logic              run;
    logic              expire;

    assign accept = rx_valid && rx_ready;
    assign busy   = (state != IDLE);

    reg_master_tmo #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (accept),
        .expire(expire)
    );

    // Frame fields are captured only on the byte that carries them and held across frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            is_write   <= 1'b0;
            addr       <= '0;
            write_data <= '0;
            rd_buf     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                case (state)
                    IDLE:    is_write <= (rx_data == OP_WR);
                    ADDR_HI: addr[ADDR_W-1:8] <= rx_data[5:0];
                    ADDR_LO: addr[7:0] <= rx_data;
                    DATA_HI: write_data[15:8] <= rx_data;
                    DATA_LO: write_data[7:0] <= rx_data;
                    default: ;
                endcase
            end
            if (state == READ) begin
                rd_buf <= read_data;
            end
        end
    end

    always_comb begin
        state_next    = state;
        rx_ready      = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        timeout_pulse = 1'b0;
        run           = 1'b0;
        case (state)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_next = (rx_data == OP_WR || rx_data == OP_RD) ? ADDR_HI : ERR;
                end
            end
            ADDR_HI: begin
                rx_ready = 1'b1;
                run      = 1'b1;
                if (rx_valid) state_next = ADDR_LO;
            end
            ADDR_LO: begin
                rx_ready = 1'b1;
                run      = 1'b1;
                if (rx_valid) state_next = is_write ? DATA_HI : READ;
            end
            DATA_HI: begin
                rx_ready = 1'b1;
                run      = 1'b1;
                if (rx_valid) state_next = DATA_LO;
            end
            DATA_LO: begin
                rx_ready = 1'b1;
                run      = 1'b1;
                if (rx_valid) state_next = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
`ifdef REG_MASTER_WR_ACK_EN
                state_next = ACK;
`else
                state_next = IDLE;
`endif
            end
            READ: begin
                rd_en      = 1'b1;
                state_next = RESP_HI;
            end
            RESP_HI: begin
                tx_valid = 1'b1;
                tx_data  = rd_buf[15:8];
                if (tx_ready) state_next = RESP_LO;
            end
            RESP_LO: begin
                tx_valid = 1'b1;
                tx_data  = rd_buf[7:0];
                if (tx_ready) state_next = IDLE;
            end
`ifdef REG_MASTER_WR_ACK_EN
            ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) state_next = IDLE;
            end
`endif
            ERR: begin
                tx_valid = 1'b1;
                tx_data  = ERR_BYTE;
                if (tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A byte arriving in the expiry cycle keeps the frame alive.
        if (expire && !accept) begin
            state_next    = IDLE;
            timeout_pulse = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: directed frames plus randomized frames
// checked against a frame-level reference model (expected strobes, cycles and response bytes).
module tb_reg_bus_master;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wr_en;
    logic        rd_en;
    logic [13:0] addr;
    logic [15:0] write_data;
    logic [15:0] rd_value;
    logic        busy;
    logic        timeout_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int proto_errs = 0;
    bit stall_mode = 1'b0;

    logic [13:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [13:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    int          tmo_cyc_q[$];

    logic       prev_wr, prev_rd, prev_stall;
    logic [7:0] prev_tx;

    reg_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (rd_value),
        .busy         (busy),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        if (stall_mode) begin
            #1;
            tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Bus and link observer: records every strobe, response byte and timeout with its cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_wr = 1'b0;
            prev_rd = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (wr_en) begin
                wr_addr_q.push_back(addr);
                wr_data_q.push_back(write_data);
                wr_cyc_q.push_back(cyc);
            end
            if (rd_en) begin
                rd_addr_q.push_back(addr);
                rd_cyc_q.push_back(cyc);
            end
            if (wr_en && rd_en) proto_errs++;
            if ((wr_en && prev_wr) || (rd_en && prev_rd)) proto_errs++;
            if (tx_valid && prev_stall && tx_data !== prev_tx) proto_errs++;
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_data);
                tx_cyc_q.push_back(cyc);
            end
            if (timeout_pulse) tmo_cyc_q.push_back(cyc);
            if (rx_valid && rx_ready) last_acc = cyc;
            prev_wr = wr_en;
            prev_rd = rd_en;
            prev_stall = tx_valid && !tx_ready;
            prev_tx = tx_data;
        end
    end

    task automatic clear_queues();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        tx_q.delete(); tx_cyc_q.delete(); tmo_cyc_q.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_byte: rx_ready=%b after %0d cycles, required 1", rx_ready, n);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_wait: busy=%b, required 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [43:0] obs;
        logic [43:0] exp;
        obs = {wr_en, rd_en, addr, write_data, tx_valid, tx_data, busy, timeout_pulse, rx_ready};
        exp = {1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: outputs=%h, required %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] d);
        int n;
        int ea;
        clear_queues();
        send_byte(8'h57);
        send_byte(hi);
        send_byte(lo);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        n = last_acc;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_strobe: wr_en=%b, required 1", wr_en);
        end
        @(posedge clk); #1; @(negedge clk);
`ifdef REG_MASTER_WR_ACK_EN
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin
            errors++;
            $display("[TB] FAIL ack_byte: tx_valid=%b tx_data=%h, required 1/06", tx_valid, tx_data);
        end
`else
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_idle: busy=%b, required 0", busy);
        end
`endif
        @(posedge clk); #1;
        wait_idle();
        ea = (int'(hi) % 64) * 256 + int'(lo);
        checks++;
        if (wr_addr_q.size() != 1 || rd_addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL write_count: wr=%0d rd=%0d, required 1/0", wr_addr_q.size(), rd_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 14'(ea) || wr_data_q[0] !== d || wr_cyc_q[0] != n + 1) begin
                errors++;
                $display("[TB] FAIL write_access: addr=%h data=%h cyc=%0d, required %h %h %0d",
                         wr_addr_q[0], wr_data_q[0], wr_cyc_q[0], 14'(ea), d, n + 1);
            end
        end
        checks++;
`ifdef REG_MASTER_WR_ACK_EN
        if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
`else
        if (tx_q.size() != 0) begin
`endif
            errors++;
            $display("[TB] FAIL write_tx: %0d response bytes, wrong count or value", tx_q.size());
        end
    endtask

    task automatic do_read(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] val,
                           input bit timing, input int gap);
        int n;
        int ea;
        clear_queues();
        rd_value = val;
        send_byte(8'h52);
        send_byte(hi);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        send_byte(lo);
        n = last_acc;
        wait_idle();
        ea = (int'(hi) % 64) * 256 + int'(lo);
        checks++;
        if (rd_addr_q.size() != 1 || wr_addr_q.size() != 0 || tmo_cyc_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL read_count: rd=%0d wr=%0d tmo=%0d, required 1/0/0",
                     rd_addr_q.size(), wr_addr_q.size(), tmo_cyc_q.size());
        end else begin
            checks++;
            if (rd_addr_q[0] !== 14'(ea) || rd_cyc_q[0] != n + 1) begin
                errors++;
                $display("[TB] FAIL read_access: addr=%h cyc=%0d, required %h %0d",
                         rd_addr_q[0], rd_cyc_q[0], 14'(ea), n + 1);
            end
        end
        checks++;
        if (tx_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL read_tx_count: %0d bytes, required 2", tx_q.size());
        end else begin
            checks++;
            if (tx_q[0] !== 8'(int'(val) / 256) || tx_q[1] !== 8'(int'(val) % 256)) begin
                errors++;
                $display("[TB] FAIL read_tx: %h %h, required %h %h", tx_q[0], tx_q[1],
                         8'(int'(val) / 256), 8'(int'(val) % 256));
            end
            if (timing) begin
                checks++;
                if (tx_cyc_q[0] != n + 2) begin
                    errors++;
                    $display("[TB] FAIL read_latency: first byte cyc=%0d, required %0d", tx_cyc_q[0], n + 2);
                end
            end
        end
    endtask

    task automatic do_bad(input logic [7:0] op);
        clear_queues();
        send_byte(op);
        wait_idle();
        checks++;
        if (tx_q.size() != 1 || wr_addr_q.size() != 0 || rd_addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL bad_op_count: tx=%0d wr=%0d rd=%0d, required 1/0/0",
                     tx_q.size(), wr_addr_q.size(), rd_addr_q.size());
        end else begin
            checks++;
            if (tx_q[0] !== 8'hEE) begin
                errors++;
                $display("[TB] FAIL bad_op_byte: %h, required EE", tx_q[0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h57;
        tx_ready = 1'b1;
        rd_value = 16'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_consume: busy=%b, required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        do_write(8'h04, 8'h01, 16'h002A);
        do_write(8'hFF, 8'hFF, 16'hFFFF);
    endtask

    task automatic test_read();
        do_read(8'h04, 8'h0B, 16'h1234, 1'b1, 0);
        do_read(8'hC0, 8'h00, 16'h8001, 1'b1, 0);
    endtask

    task automatic test_bad_opcode();
        do_bad(8'h41);
        do_read(8'h04, 8'h0B, 16'h1234, 1'b1, 0);
    endtask

    task automatic test_timeout();
        logic [7:0] frame[5];
        int n;
        frame = '{8'h57, 8'h04, 8'h01, 8'h00, 8'h2A};
        for (int k = 2; k <= 5; k++) begin
            if (k == 5) k = 1;
            clear_queues();
            for (int j = 0; j < k; j++) send_byte(frame[j]);
            n = last_acc;
            repeat (TMO + 3) @(posedge clk);
            #1;
            checks++;
            if (tmo_cyc_q.size() != 1 || wr_addr_q.size() != 0 || tx_q.size() != 0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_abort: pulses=%0d wr=%0d tx=%0d busy=%b, required 1/0/0/0",
                         tmo_cyc_q.size(), wr_addr_q.size(), tx_q.size(), busy);
            end else begin
                checks++;
                if (tmo_cyc_q[0] != n + TMO) begin
                    errors++;
                    $display("[TB] FAIL timeout_cycle: cyc=%0d, required %0d", tmo_cyc_q[0], n + TMO);
                end
            end
            do_read(8'h04, 8'h01, 16'($urandom), 1'b1, 0);
            if (k == 1) break;
        end
        // Byte arriving exactly in the would-be expiry cycle must win.
        do_read(8'h12, 8'h34, 16'hA55A, 1'b1, TMO - 1);
    endtask

    task automatic test_backpressure();
        int n = 0;
        clear_queues();
        rd_value = 16'h1234;
        tx_ready = 1'b0;
        send_byte(8'h52);
        send_byte(8'h04);
        send_byte(8'h0B);
        rx_valid = 1'b1;
        rx_data = 8'h57;
        @(negedge clk);
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h12 || rx_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold: tx_valid=%b tx_data=%h rx_ready=%b, required 1/12/0",
                         tx_valid, tx_data, rx_ready);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        send_byte(8'h57);
        send_byte(8'h04);
        send_byte(8'h02);
        send_byte(8'hAB);
        send_byte(8'hCD);
        wait_idle();
        checks++;
        if (rd_addr_q.size() != 1 || wr_addr_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL stall_counts: rd=%0d wr=%0d, required 1/1", rd_addr_q.size(), wr_addr_q.size());
        end else begin
            checks++;
            if (rd_addr_q[0] !== 14'h040B || wr_addr_q[0] !== 14'h0402 || wr_data_q[0] !== 16'hABCD) begin
                errors++;
                $display("[TB] FAIL stall_access: rd=%h wr=%h data=%h, required 040B 0402 ABCD",
                         rd_addr_q[0], wr_addr_q[0], wr_data_q[0]);
            end
        end
        checks++;
        if (tx_q.size() < 2 || tx_q[0] !== 8'h12 || tx_q[1] !== 8'h34) begin
            errors++;
            $display("[TB] FAIL stall_tx: %0d bytes, required 12 34 first", tx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_queues();
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h57); send_byte(8'h02); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        wait_idle();
`ifdef REG_MASTER_WR_ACK_EN
        gap = 7;
`else
        gap = 6;
`endif
        checks++;
        if (wr_addr_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: wr=%0d, required 2", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_cyc_q[1] - wr_cyc_q[0] != gap || wr_addr_q[1] !== 14'h0244 || wr_data_q[1] !== 16'h5566) begin
                errors++;
                $display("[TB] FAIL b2b_write: spacing=%0d addr=%h data=%h, required %0d 0244 5566",
                         wr_cyc_q[1] - wr_cyc_q[0], wr_addr_q[1], wr_data_q[1], gap);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_queues();
        send_byte(8'h57); send_byte(8'h3F); send_byte(8'h77);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_in_data_hi");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_write(8'h05, 8'h5A, 16'hC3C3);
        tx_ready = 1'b0;
        rd_value = 16'hBEEF;
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h02);
        @(negedge clk);
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEF) begin
            errors++;
            $display("[TB] FAIL resp_lo_reached: tx_valid=%b tx_data=%h, required 1/EF", tx_valid, tx_data);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_in_resp_lo");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tx_ready = 1'b1;
        do_write(8'h04, 8'h01, 16'h002A);
    endtask

    task automatic test_random();
        int kind;
        logic [7:0] op;
        for (int i = 0; i < 16; i++) begin
            stall_mode = (i >= 8);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                do_write(8'($urandom), 8'($urandom), 16'($urandom));
            end else if (kind == 1) begin
                do_read(8'($urandom), 8'($urandom), 16'($urandom), !stall_mode, 0);
            end else begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                do_bad(op);
            end
        end
        stall_mode = 1'b0;
        @(posedge clk); #2;
        tx_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (proto_errs != 0) begin
            errors++;
            $display("[TB] FAIL protocol: %0d strobe/stability violations, required 0", proto_errs);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
